// File: rtl/ne555_multi_timer.sv
// NCH independent 555-style timers (mono / astable / burst / delayed) sharing one prescaler.
// Trigger edge to state change takes one cycle; outputs decode registers only; no backpressure.
module ne555_multi_timer #(
  parameter int NCH   = 4,
  parameter int CW    = 16,
  parameter int PRE_W = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PRE_W-1:0] presc_div,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [CW-1:0]    cfg_wdata,
  input  logic [NCH-1:0]   trig,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   active
);

  typedef enum logic [1:0] {S_IDLE, S_DLY, S_HI, S_LO} state_t;

  localparam logic [1:0] M_MONO  = 2'd0;
  localparam logic [1:0] M_AST   = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;
  localparam logic [1:0] M_DLY   = 2'd3;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  assign tick = ena && (pre_q == presc_div);

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (!ena || sync || tick) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d, bc_q, bc_d;
    logic [CW-1:0] high_q, low_q, burst_q;
    logic [4:0]    ctrl_q;
    logic          trig_q, done_q, done_d;
    logic          wr, edge_det, abort, retrig_hit, phase_end, last_pulse;
    logic [CW-1:0] h_m1, l_m1, b_m1, lim_m1;
    logic [1:0]    mode;

    assign mode = ctrl_q[2:1];
    assign wr   = cfg_we && (cfg_ch == CHW'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q  <= '0;
        high_q  <= '0;
        low_q   <= '0;
        burst_q <= '0;
      end else if (wr) begin
        case (cfg_sel)
          2'd0:    ctrl_q  <= cfg_wdata[4:0];
          2'd1:    high_q  <= cfg_wdata;
          2'd2:    low_q   <= cfg_wdata;
          default: burst_q <= cfg_wdata;
        endcase
      end
    end

    // Zero-valued duration registers behave as one tick.
    assign h_m1   = (high_q  == '0) ? '0 : high_q  - CW'(1);
    assign l_m1   = (low_q   == '0) ? '0 : low_q   - CW'(1);
    assign b_m1   = (burst_q == '0) ? '0 : burst_q - CW'(1);
    assign lim_m1 = (st_q == S_HI) ? h_m1 : l_m1;

    assign phase_end  = tick && (cnt_q >= lim_m1);
    assign last_pulse = (bc_q >= b_m1);
    assign edge_det   = trig[i] && !trig_q;

    assign abort = (st_q != S_IDLE) &&
                   (!ctrl_q[0] ||
                    (wr && (cfg_sel == 2'd0) && (!cfg_wdata[0] || (cfg_wdata[2:1] != mode))));

    assign retrig_hit = ctrl_q[4] && edge_det &&
                        (((mode == M_MONO)  && (st_q == S_HI)) ||
                         ((mode == M_BURST) && ((st_q == S_HI) || (st_q == S_LO))) ||
                         ((mode == M_DLY)   && (st_q == S_DLY)));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      bc_d   = bc_q;
      done_d = 1'b0;
      if (!ena || abort) begin
        st_d  = S_IDLE;
        cnt_d = '0;
        bc_d  = '0;
      end else if (st_q == S_IDLE) begin
        cnt_d = '0;
        bc_d  = '0;
        if (ctrl_q[0]) begin
          if (mode == M_AST)  st_d = S_HI;
          else if (edge_det)  st_d = (mode == M_DLY) ? S_DLY : S_HI;
        end
      end else if (sync) begin
        cnt_d = '0;
      end else if (retrig_hit) begin
        cnt_d = '0;
        if (mode == M_BURST) begin
          st_d = S_HI;
          bc_d = '0;
        end
      end else if (tick) begin
        if (!phase_end) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          case (st_q)
            S_DLY: st_d = S_HI;
            S_LO:  st_d = S_HI;
            S_HI: begin
              if (mode == M_AST) begin
                st_d = S_LO;
              end else if (mode == M_BURST && !last_pulse) begin
                st_d = S_LO;
                bc_d = bc_q + CW'(1);
              end else begin
                st_d   = S_IDLE;
                bc_d   = '0;
                done_d = 1'b1;
              end
            end
            default: st_d = S_IDLE;
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= S_IDLE;
        cnt_q  <= '0;
        bc_q   <= '0;
        trig_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        bc_q   <= bc_d;
        trig_q <= trig[i];
        done_q <= done_d;
      end
    end

    assign out[i]    = (st_q == S_HI) ^ ctrl_q[3];
    assign done[i]   = done_q;
    assign active[i] = (st_q != S_IDLE);
  end

endmodule

// File: tb/tb_ne555_multi_timer.sv
// Directed scenarios plus random stimulus against a phase/elapsed-tick model of the timer rules.
module tb_ne555_multi_timer;
  localparam int NCH   = 4;
  localparam int CW    = 16;
  localparam int PRE_W = 16;
  localparam int P_IDLE = 0, P_DLY = 1, P_HI = 2, P_LO = 3;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic [PRE_W-1:0] presc_div;
  logic             sync;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_sel;
  logic [CW-1:0]    cfg_wdata;
  logic [NCH-1:0]   trig;
  logic [NCH-1:0]   out;
  logic [NCH-1:0]   done;
  logic [NCH-1:0]   active;

  ne555_multi_timer #(.NCH(NCH), .CW(CW), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .presc_div(presc_div), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .trig(trig), .out(out), .done(done), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Reference model: phase kind, ticks elapsed in phase, high phases finished.
  int         m_ph[NCH], m_el[NCH], m_np[NCH];
  bit         m_dn[NCH], m_tp[NCH];
  logic [4:0] m_ctrl[NCH];
  int         m_hi[NCH], m_lo[NCH], m_bu[NCH];
  int         m_pre;
  int         o_hi[NCH], o_dn[NCH], o_ac[NCH];

  function automatic int mx1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pre = 0;
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = P_IDLE; m_el[c] = 0; m_np[c] = 0; m_dn[c] = 0; m_tp[c] = 0;
      m_ctrl[c] = '0; m_hi[c] = 0; m_lo[c] = 0; m_bu[c] = 0;
    end
  endtask

  task automatic clr_obs();
    for (int c = 0; c < NCH; c++) begin
      o_hi[c] = 0; o_dn[c] = 0; o_ac[c] = 0;
    end
  endtask

  // One clock: predict from current inputs, clock the DUT, compare all outputs.
  task automatic cyc();
    int n_ph[NCH], n_el[NCH], n_np[NCH];
    bit n_dn[NCH];
    bit tk;
    int n_pre;
    logic [NCH-1:0] e_out, e_dn, e_ac;
    tk    = ena && (m_pre == int'(presc_div));
    n_pre = (!ena || sync || tk) ? 0 : (m_pre + 1) % 65536;
    for (int c = 0; c < NCH; c++) begin
      int md, lim, bl;
      bit en, rt, edg, kill, elig;
      md   = int'(m_ctrl[c][2:1]);
      en   = m_ctrl[c][0];
      rt   = m_ctrl[c][4];
      lim  = (m_ph[c] == P_HI) ? mx1(m_hi[c]) : mx1(m_lo[c]);
      bl   = mx1(m_bu[c]);
      edg  = trig[c] && !m_tp[c];
      kill = cfg_we && (int'(cfg_ch) == c) && (cfg_sel == 2'd0) &&
             (!cfg_wdata[0] || int'(cfg_wdata[2:1]) != md);
      elig = (md == 0 && m_ph[c] == P_HI) || (md == 2 && (m_ph[c] == P_HI || m_ph[c] == P_LO)) ||
             (md == 3 && m_ph[c] == P_DLY);
      n_ph[c] = m_ph[c]; n_el[c] = m_el[c]; n_np[c] = m_np[c]; n_dn[c] = 0;
      if (!ena || (m_ph[c] != P_IDLE && (!en || kill))) begin
        n_ph[c] = P_IDLE; n_el[c] = 0; n_np[c] = 0;
      end else if (m_ph[c] == P_IDLE) begin
        n_el[c] = 0; n_np[c] = 0;
        if (en && md == 1) n_ph[c] = P_HI;
        else if (en && edg) n_ph[c] = (md == 3) ? P_DLY : P_HI;
      end else if (sync) begin
        n_el[c] = 0;
      end else if (rt && edg && elig) begin
        n_el[c] = 0;
        if (md == 2) begin n_ph[c] = P_HI; n_np[c] = 0; end
      end else if (tk) begin
        if (m_el[c] + 1 < lim) n_el[c] = m_el[c] + 1;
        else begin
          n_el[c] = 0;
          if (m_ph[c] == P_DLY || m_ph[c] == P_LO) n_ph[c] = P_HI;
          else if (md == 1) n_ph[c] = P_LO;
          else if (md == 2 && m_np[c] + 1 < bl) begin n_ph[c] = P_LO; n_np[c] = m_np[c] + 1; end
          else begin n_ph[c] = P_IDLE; n_np[c] = 0; n_dn[c] = 1; end
        end
      end
    end
    @(posedge clk);
    #1;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: m_ctrl[cfg_ch] = cfg_wdata[4:0];
        2'd1: m_hi[cfg_ch]   = int'(cfg_wdata);
        2'd2: m_lo[cfg_ch]   = int'(cfg_wdata);
        default: m_bu[cfg_ch] = int'(cfg_wdata);
      endcase
    end
    m_pre = n_pre;
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = n_ph[c]; m_el[c] = n_el[c]; m_np[c] = n_np[c]; m_dn[c] = n_dn[c];
      m_tp[c] = trig[c];
      e_out[c] = (m_ph[c] == P_HI) ^ m_ctrl[c][3];
      e_dn[c]  = m_dn[c];
      e_ac[c]  = (m_ph[c] != P_IDLE);
      o_hi[c] += int'(out[c]);
      o_dn[c] += int'(done[c]);
      o_ac[c] += int'(active[c]);
    end
    chk("out", 32'(out), 32'(e_out));
    chk("done", 32'(done), 32'(e_dn));
    chk("active", 32'(active), 32'(e_ac));
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_wdata = 16'(data);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input int ch);
    trig[ch] = 1'b1;
    cyc();
    trig[ch] = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int w;
    int found;
    rst_n = 1'b1; ena = 1'b0; presc_div = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0; trig = '0;
    m_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Mono, HIGH=5: five high cycles, one done pulse.
    wr(0, 1, 5); wr(0, 0, 1);
    run(2); clr_obs();
    pulse(0); run(9);
    chk("t1_hi", 32'(o_hi[0]), 32'd5);
    chk("t1_done", 32'(o_dn[0]), 32'd1);
    chk("t1_act", 32'(o_ac[0]), 32'd5);

    // Astable, presc=1, HIGH=3 LOW=2: steady period 10 with 6 high.
    presc_div = 16'd1;
    wr(1, 1, 3); wr(1, 2, 2); wr(1, 0, 3);
    run(20); clr_obs(); run(20);
    chk("t2_hi", 32'(o_hi[1]), 32'd12);
    chk("t2_done", 32'(o_dn[1]), 32'd0);
    chk("t2_others", 32'(o_ac[0] + o_ac[2] + o_ac[3]), 32'd0);
    wr(1, 0, 2);
    presc_div = 16'd0;
    run(2);

    // Burst x3, HIGH=2 LOW=2: 6 high cycles, 10 active, one done.
    wr(2, 3, 3); wr(2, 1, 2); wr(2, 2, 2); wr(2, 0, 5);
    clr_obs(); pulse(2); run(13);
    chk("t3_hi", 32'(o_hi[2]), 32'd6);
    chk("t3_act", 32'(o_ac[2]), 32'd10);
    chk("t3_done", 32'(o_dn[2]), 32'd1);

    // Delayed, LOW=4 HIGH=1: 4 delay cycles then 1 high, one done.
    wr(3, 2, 4); wr(3, 1, 1); wr(3, 0, 7);
    clr_obs(); pulse(3); run(7);
    chk("t4_hi", 32'(o_hi[3]), 32'd1);
    chk("t4_act", 32'(o_ac[3]), 32'd5);
    chk("t4_done", 32'(o_dn[3]), 32'd1);

    // Mono HIGH=8, second edge after 4 high cycles: retrig gives 4+8, no retrig gives 8.
    wr(0, 1, 8); wr(0, 0, 17);
    clr_obs(); pulse(0); run(3); pulse(0); run(14);
    chk("t5_retrig_hi", 32'(o_hi[0]), 32'd12);
    chk("t5_retrig_done", 32'(o_dn[0]), 32'd1);
    wr(0, 0, 1);
    clr_obs(); pulse(0); run(3); pulse(0); run(14);
    chk("t5_noretrig_hi", 32'(o_hi[0]), 32'd8);
    wr(0, 1, 0);
    clr_obs(); pulse(0); run(4);
    chk("t5_zero_hi", 32'(o_hi[0]), 32'd1);

    // Sync while astable HI with one tick elapsed: full 3-tick high phase follows.
    wr(1, 1, 3); wr(1, 2, 2); wr(1, 0, 3);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (m_ph[1] == P_HI && m_el[1] == 1) found = 1;
      else cyc();
    end
    chk("t6_found", 32'(found), 32'd1);
    clr_obs();
    sync = 1'b1; cyc(); sync = 1'b0;
    run(4);
    chk("t6_sync_hi", 32'(o_hi[1]), 32'd3);
    ena = 1'b0; cyc();
    chk("t6_ena_off", 32'(active), 32'h0);
    ena = 1'b1; run(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", 32'(out), 32'h0);
    chk("t6_rst_act", 32'(active), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Inverted idle channel drives 1.
    wr(2, 0, 8);
    chk("inv_idle", 32'(out[2]), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = 2'($urandom);
      cfg_sel = 2'($urandom);
      if (cfg_sel == 2'd0) begin
        w = int'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) w = w | 1;
      end else begin
        w = int'($urandom_range(0, 5));
      end
      cfg_wdata = 16'(w);
      sync = ($urandom_range(0, 39) == 0);
      if (sync && $urandom_range(0, 1) == 1) presc_div = 16'($urandom_range(0, 2));
      ena = ($urandom_range(0, 79) != 0);
      cyc();
    end
    cfg_we = 1'b0; sync = 1'b0; ena = 1'b1; trig = '0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
